// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry and FSM encoding for the direct-mapped
// data cache (8 lines x 4-byte blocks, 8-bit byte address).
package data_cache_pkg;
  localparam int TAG_W     = 3;
  localparam int IDX_W     = 3;
  localparam int OFF_W     = 2;
  localparam int NUM_LINES = 8;
  localparam int BYTE_W    = 8;
  localparam int BLK_W     = 32;
  localparam int ADDR_W    = TAG_W + IDX_W + OFF_W;
  localparam int MADDR_W   = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    MEM_FETCH,
    UPDATE
  } state_t;
endpackage

// File: rtl/data_cache_byte_select.sv
// data_cache_byte_select: byte lane read mux and store-byte merge for one
// 32-bit cache block.
//   blk    - block as stored in the line (byte 0 in [7:0])
//   offset - byte offset within the block
//   wbyte  - store byte to merge
//   rbyte  - selected byte of blk
//   merged - blk with lane `offset` replaced by wbyte
module data_cache_byte_select
  import data_cache_pkg::*;
(
  input  logic [BLK_W-1:0]  blk,
  input  logic [OFF_W-1:0]  offset,
  input  logic [BYTE_W-1:0] wbyte,
  output logic [BYTE_W-1:0] rbyte,
  output logic [BLK_W-1:0]  merged
);
  localparam int NUM_LANES = BLK_W / BYTE_W;

  logic [NUM_LANES-1:0][BYTE_W-1:0] lanes, mlanes;

  assign lanes  = blk;
  assign rbyte  = lanes[offset];
  assign merged = mlanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mlanes[i] = (offset == OFF_W'(i)) ? wbyte : lanes[i];
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between
// the 8-bit CPU load/store port and 32-bit-block data memory.
//   CLK, RESET (async, active low)
//   CPU side : READ, WRITE, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT
//   Mem side : MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
//              MEM_READDATA, MEM_BUSYWAIT
// Every access stalls at least one cycle; a miss writes back a dirty victim,
// fetches the block, installs it (UPDATE) and then completes as a hit.
module data_cache
  import data_cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BYTE_W-1:0]  WRITEDATA,
  output logic [BYTE_W-1:0]  READDATA,
  output logic               BUSYWAIT,
  input  logic               MEM_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLK_W-1:0]   MEM_READDATA,
  output logic [BLK_W-1:0]   MEM_WRITEDATA
);
  logic [NUM_LINES-1:0][BLK_W-1:0] data_q;
  logic [NUM_LINES-1:0][TAG_W-1:0] tag_q;
  logic [NUM_LINES-1:0]            valid_q, dirty_q;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic              done_q;     // high for the one cycle after a hit completes
  logic              mem_acc_q;  // memory has seen at least one edge of the request

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;
  logic              req, hit, hit_done, miss;
  logic [BYTE_W-1:0] rbyte;
  logic [BLK_W-1:0]  merged;

  assign cpu_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign cpu_idx = ADDRESS[OFF_W +: IDX_W];
  assign cpu_off = ADDRESS[OFF_W-1:0];

  assign req      = READ | WRITE;
  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // New requests are only looked at in IDLE; done_q masks the cycle in which
  // the CPU still holds the request it just had served.
  assign hit_done = (state_q == IDLE) && req && hit && !done_q;
  assign miss     = (state_q == IDLE) && req && !hit && !done_q;

  data_cache_byte_select u_bsel (
    .blk    (data_q[cpu_idx]),
    .offset (cpu_off),
    .wbyte  (WRITEDATA),
    .rbyte  (rbyte),
    .merged (merged)
  );

  assign READDATA = hit ? rbyte : '0;
  // RESET gating makes the stall drop the instant reset asserts, even with a
  // request held by the CPU.
  assign BUSYWAIT = RESET & req & ~done_q;

  always_comb begin
    state_d       = state_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      IDLE: begin
        if (miss) state_d = dirty_q[cpu_idx] ? WRITE_BACK : MEM_FETCH;
      end
      WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[req_idx_q], req_idx_q};
        MEM_WRITEDATA = data_q[req_idx_q];
        if (mem_acc_q && !MEM_BUSYWAIT) state_d = MEM_FETCH;
      end
      MEM_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {req_tag_q, req_idx_q};
        if (mem_acc_q && !MEM_BUSYWAIT) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      done_q    <= 1'b0;
      mem_acc_q <= 1'b0;
      req_tag_q <= '0;
      req_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= hit_done;
      // Only a busy-low seen after the first edge of a request counts as
      // completion; a slow-to-respond memory cannot be skipped past.
      mem_acc_q <= ((state_q == WRITE_BACK) || (state_q == MEM_FETCH)) &&
                   (state_d == state_q);
      if (miss) begin
        req_tag_q <= cpu_tag;
        req_idx_q <= cpu_idx;
      end
      if (state_q == UPDATE) begin
        valid_q[req_idx_q] <= 1'b1;
        dirty_q[req_idx_q] <= 1'b0;
      end else if (hit_done && WRITE) begin
        dirty_q[cpu_idx] <= 1'b1;
      end
    end
  end

  // Block data and tags need no reset: Valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (state_q == UPDATE) begin
      data_q[req_idx_q] <= MEM_READDATA;
      tag_q[req_idx_q]  <= req_tag_q;
    end else if (hit_done && WRITE) begin
      data_q[cpu_idx] <= merged;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  localparam int MEM_LAT = 3;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_exp_t;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_READDATA, MEM_WRITEDATA;

  logic        mem_ack;
  int          mem_cnt;
  logic [7:0]  mem_bytes [256];
  logic [7:0]  ref_bytes [256];
  mem_exp_t    exp_q [$];
  mem_exp_t    e_mon;
  logic [7:0]  rd_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA), .MEM_WRITEDATA(MEM_WRITEDATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  function automatic logic [31:0] blk(input logic [5:0] b);
    return {ref_bytes[{b, 2'd3}], ref_bytes[{b, 2'd2}],
            ref_bytes[{b, 2'd1}], ref_bytes[{b, 2'd0}]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input bit wr, input logic [5:0] addr, input logic [31:0] data);
    mem_exp_t m;
    m.wr = wr; m.addr = addr; m.data = data;
    exp_q.push_back(m);
  endtask

  // Memory: busy while requested, serves on the MEM_LAT-th negedge, then
  // holds busy low for one cycle so the cache can move on.
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & ~mem_ack;

  always @(negedge CLK) begin
    if (!RESET) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt < MEM_LAT - 1) begin
        mem_cnt++;
      end else begin
        mem_cnt = 0;
        mem_ack = 1'b1;
        chk("mem_rd_wr_exclusive", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("mem_unexpected_op", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("mem_op_is_write", {31'd0, MEM_WRITE}, {31'd0, e_mon.wr});
          chk("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, e_mon.addr});
          if (e_mon.wr) chk("mem_writeback_data", MEM_WRITEDATA, e_mon.data);
        end
        for (int i = 0; i < 4; i++) begin
          if (MEM_WRITE) mem_bytes[{MEM_ADDRESS, 2'(i)}] = MEM_WRITEDATA[8*i +: 8];
          else           MEM_READDATA[8*i +: 8] = mem_bytes[{MEM_ADDRESS, 2'(i)}];
        end
      end
    end
  end

  task automatic drive(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit miss);
    @(negedge CLK);
    ADDRESS = a; WRITE = wr; READ = ~wr; WRITEDATA = d;
    if (wr) ref_bytes[a] = d;
    else    rd_q.push_back(ref_bytes[a]);
    if (miss) begin
      #1;
      chk("readdata_on_miss", {24'd0, READDATA}, 32'd0);
    end
  endtask

  task automatic wait_done(input bit wr, output int n);
    logic [7:0] exp_rd;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (BUSYWAIT === 1'b1 && n < 200);
    chk("busywait_release", {31'd0, BUSYWAIT}, 32'd0);
    if (!wr) begin
      exp_rd = rd_q.pop_front();
      chk("readdata", {24'd0, READDATA}, {24'd0, exp_rd});
    end
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic acc(input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input bit miss, output int n);
    drive(wr, a, d, miss);
    wait_done(wr, n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_bytes[i] = init_byte(i);
      ref_bytes[i] = init_byte(i);
    end
    MEM_READDATA = '0;

    // Reset with a request held: everything quiet.
    RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h42; WRITEDATA = 8'h00;
    #12;
    chk("reset_busywait",  {31'd0, BUSYWAIT},  32'd0);
    chk("reset_mem_read",  {31'd0, MEM_READ},  32'd0);
    chk("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("reset_mem_addr",  {26'd0, MEM_ADDRESS}, 32'd0);
    chk("reset_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("reset_readdata",  {24'd0, READDATA}, 32'd0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    // Clean write miss to line 0.
    exp_mem(1'b0, 6'h00, 32'h0);
    acc(1'b1, 8'h02, 8'h02, 1'b0, stall);
    chk("clean_miss_stall", stall, MEM_LAT + 3);

    // Dirty conflict on line 0: write-back of block 0, then fetch block 8.
    exp_mem(1'b1, 6'h00, blk(6'h00));
    exp_mem(1'b0, 6'h08, 32'h0);
    acc(1'b1, 8'h22, 8'h02, 1'b0, stall);

    // Read miss on another dirty conflict.
    exp_mem(1'b1, 6'h08, blk(6'h08));
    exp_mem(1'b0, 6'h10, 32'h0);
    acc(1'b0, 8'h42, 8'h00, 1'b1, stall);

    // Write miss to an invalid line: fetch only.
    exp_mem(1'b0, 6'h01, 32'h0);
    acc(1'b1, 8'h06, 8'h77, 1'b0, stall);

    // Hits: one stall cycle each, no memory traffic.
    acc(1'b0, 8'h42, 8'h00, 1'b0, stall);
    chk("read_hit_stall", stall, 1);
    acc(1'b0, 8'h06, 8'h00, 1'b0, stall);
    chk("read_hit_stall_b", stall, 1);
    acc(1'b0, 8'h05, 8'h00, 1'b0, stall);
    acc(1'b1, 8'h42, 8'h11, 1'b0, stall);
    chk("write_hit_stall", stall, 1);

    // Evict the now-dirty tag-2 line and read back the earlier write-back.
    exp_mem(1'b1, 6'h10, blk(6'h10));
    exp_mem(1'b0, 6'h08, 32'h0);
    acc(1'b0, 8'h22, 8'h00, 1'b1, stall);

    // Reset during a fetch.
    drive(1'b0, 8'h63, 8'h00, 1'b1);
    for (int k = 0; k < 20 && MEM_READ !== 1'b1; k++) begin
      @(posedge CLK); #1;
    end
    chk("fetch_started", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("midreset_busywait",  {31'd0, BUSYWAIT},  32'd0);
    chk("midreset_mem_read",  {31'd0, MEM_READ},  32'd0);
    chk("midreset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("midreset_mem_addr",  {26'd0, MEM_ADDRESS}, 32'd0);
    chk("midreset_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("midreset_readdata",  {24'd0, READDATA}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    // Line 1 was dirty with 0x77 at byte 6; reset drops it.
    ref_bytes[8'h06] = init_byte(8'h06);
    exp_mem(1'b0, 6'h18, 32'h0);
    wait_done(1'b0, stall);

    // All lines invalid after reset: line 1 misses again.
    exp_mem(1'b0, 6'h01, 32'h0);
    acc(1'b0, 8'h06, 8'h00, 1'b1, stall);

    repeat (3) @(posedge CLK);
    chk("mem_queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
